cdb_broadcast_arbiter: RTL and testbench

CDB_BROADCAST_ARBITER -- requirements
Module: cdb_broadcast_arbiter

---
 rtl/cdb_broadcast_arbiter_if.sv | 26 ++
 rtl/cdb_broadcast_arbiter.sv | 94 +++++++++
 tb/tb_cdb_broadcast_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cdb_broadcast_arbiter_if.sv
// Lane result inputs, ready back-pressure, flush and broadcast busses of the CDB arbiter.
interface cdb_broadcast_arbiter_if #(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned ROB_INDEX_WIDTH = 8,
  parameter int unsigned FORWARD_BUSSES  = 2,
  parameter int unsigned NUM_LANES       = 4
);
  logic [NUM_LANES-1:0]                      lane_valid_i;
  logic [NUM_LANES-1:0]                      lane_ready_o;
  logic [NUM_LANES*ROB_INDEX_WIDTH-1:0]      lane_ROB_index_i;
  logic [NUM_LANES*XLEN-1:0]                 lane_value_i;
  logic [FORWARD_BUSSES-1:0]                 forward_valids_o;
  logic [FORWARD_BUSSES*ROB_INDEX_WIDTH-1:0] forward_indexes_o;
  logic [FORWARD_BUSSES*XLEN-1:0]            forward_values_o;
  logic                                      flush_i;

  modport master (
    output lane_valid_i, lane_ROB_index_i, lane_value_i, flush_i,
    input  lane_ready_o, forward_valids_o, forward_indexes_o, forward_values_o
  );

  modport slave (
    input  lane_valid_i, lane_ROB_index_i, lane_value_i, flush_i,
    output lane_ready_o, forward_valids_o, forward_indexes_o, forward_values_o
  );
endinterface

// File: rtl/cdb_broadcast_arbiter.sv
// Per-lane holding registers feeding FORWARD_BUSSES registered broadcast busses,
// granted round-robin from rr_ptr.
module cdb_broadcast_arbiter #(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned ROB_INDEX_WIDTH = 8,
  parameter int unsigned FORWARD_BUSSES  = 2,
  parameter int unsigned NUM_LANES       = 4
) (
  input logic                     clock_i,
  input logic                     reset_i,
  cdb_broadcast_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0]       hold_valid;
  logic [ROB_INDEX_WIDTH-1:0] hold_idx [NUM_LANES];
  logic [XLEN-1:0]            hold_val [NUM_LANES];
  logic [PTR_W-1:0]           rr_ptr;

  logic [NUM_LANES-1:0]                      grant;
  logic [PTR_W-1:0]                          nxt_rr;
  logic [FORWARD_BUSSES-1:0]                 nxt_valids;
  logic [FORWARD_BUSSES*ROB_INDEX_WIDTH-1:0] nxt_indexes;
  logic [FORWARD_BUSSES*XLEN-1:0]            nxt_values;
  logic [PTR_W-1:0]                          lane;
  int unsigned                               cnt;

  // Scan from rr_ptr; the k-th occupied holding found goes to bus k.
  always_comb begin
    grant       = '0;
    nxt_rr      = rr_ptr;
    nxt_valids  = '0;
    nxt_indexes = '0;
    nxt_values  = '0;
    lane        = '0;
    cnt         = 0;
    if (!bus.flush_i) begin
      for (int unsigned j = 0; j < NUM_LANES; j++) begin
        lane = PTR_W'((32'(rr_ptr) + j) % NUM_LANES);
        if (hold_valid[lane] && (cnt < FORWARD_BUSSES)) begin
          grant[lane]                                   = 1'b1;
          nxt_valids[cnt]                               = 1'b1;
          nxt_indexes[cnt*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH] = hold_idx[lane];
          nxt_values[cnt*XLEN +: XLEN]                  = hold_val[lane];
          nxt_rr = PTR_W'((32'(lane) + 1) % NUM_LANES);
          cnt    = cnt + 1;
        end
      end
    end
  end

  always_comb begin
    bus.lane_ready_o = '0;
    if (!bus.flush_i)
      bus.lane_ready_o = ~hold_valid | grant;
  end

  // A refill on a granted lane wins over the clear.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        hold_idx[i] <= '0;
        hold_val[i] <= '0;
      end
    end else if (bus.flush_i) begin
      hold_valid <= '0;
    end else begin
      rr_ptr <= nxt_rr;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (bus.lane_valid_i[i] && bus.lane_ready_o[i]) begin
          hold_valid[i] <= 1'b1;
          hold_idx[i]   <= bus.lane_ROB_index_i[i*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH];
          hold_val[i]   <= bus.lane_value_i[i*XLEN +: XLEN];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      bus.forward_valids_o  <= '0;
      bus.forward_indexes_o <= '0;
      bus.forward_values_o  <= '0;
    end else begin
      bus.forward_valids_o  <= nxt_valids;
      bus.forward_indexes_o <= nxt_indexes;
      bus.forward_values_o  <= nxt_values;
    end
  end
endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Directed bench for cdb_broadcast_arbiter with hand-computed expectations.
module tb_cdb_broadcast_arbiter;
  logic clk;
  logic rst;
  int unsigned n_cmp;
  int unsigned n_err;

  cdb_broadcast_arbiter_if #(
    .XLEN(64), .ROB_INDEX_WIDTH(8), .FORWARD_BUSSES(2), .NUM_LANES(4)
  ) cab ();

  cdb_broadcast_arbiter #(
    .XLEN(64), .ROB_INDEX_WIDTH(8), .FORWARD_BUSSES(2), .NUM_LANES(4)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (cab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int unsigned l, input logic v, input logic [7:0] idx, input logic [63:0] val);
    cab.lane_valid_i[l]            = v;
    cab.lane_ROB_index_i[l*8 +: 8] = idx;
    cab.lane_value_i[l*64 +: 64]   = val;
  endtask

  task automatic clear_lanes();
    cab.lane_valid_i     = '0;
    cab.lane_ROB_index_i = '0;
    cab.lane_value_i     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_lanes();
    cab.flush_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_bus(input string tag, input logic [1:0] v, input logic [15:0] idx, input logic [127:0] val);
    check_eq({tag, "_valid"}, 256'(cab.forward_valids_o), 256'(v));
    check_eq({tag, "_index"}, 256'(cab.forward_indexes_o), 256'(idx));
    check_eq({tag, "_value"}, 256'(cab.forward_values_o), 256'(val));
  endtask

  logic [3:0]  rdy;
  int unsigned seqn [4];
  int unsigned seen [4];
  int unsigned first, m;
  logic [7:0]  e0, e1;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    cab.flush_i = 1'b0;
    clear_lanes();

    // reset state
    #3;
    check_bus("reset", 2'b00, 16'h0, 128'h0);
    do_reset();
    #1;
    check_eq("ready_after_reset", 256'(cab.lane_ready_o), 256'(4'b1111));

    // single result on lane 2
    set_lane(2, 1'b1, 8'd5, 64'd21);
    tick();
    clear_lanes();
    check_bus("single_edge1", 2'b00, 16'h0, 128'h0);
    tick();
    check_bus("single_edge2", 2'b01, 16'h0005, {64'd0, 64'd21});
    tick();
    check_bus("single_edge3", 2'b00, 16'h0, 128'h0);

    // rr_ptr now 3: lane 3 scanned before lane 0 (wrap)
    set_lane(0, 1'b1, 8'd8, 64'd80);
    set_lane(3, 1'b1, 8'd9, 64'd90);
    tick();
    clear_lanes();
    tick();
    check_bus("wrap", 2'b11, 16'h0809, {64'd80, 64'd90});

    // contention, rr_ptr 0
    do_reset();
    set_lane(0, 1'b1, 8'd3, 64'd1003);
    set_lane(1, 1'b1, 8'd4, 64'd1004);
    set_lane(2, 1'b1, 8'd6, 64'd1006);
    set_lane(3, 1'b1, 8'd7, 64'd1007);
    #1;
    check_eq("contend_ready", 256'(cab.lane_ready_o), 256'(4'b1111));
    tick();
    clear_lanes();
    tick();
    check_bus("contend_c1", 2'b11, 16'h0403, {64'd1004, 64'd1003});
    tick();
    check_bus("contend_c2", 2'b11, 16'h0706, {64'd1007, 64'd1006});
    tick();
    check_eq("contend_idle", 256'(cab.forward_valids_o), 256'(2'b00));

    // fairness: all lanes valid for 8 edges
    do_reset();
    for (int unsigned l = 0; l < 4; l++) begin
      seqn[l] = 0;
      seen[l] = 0;
      set_lane(l, 1'b1, 8'(l*16), 64'(l*16 + 1000));
    end
    for (int unsigned e = 1; e <= 9; e++) begin
      #1;
      rdy = cab.lane_ready_o;
      if (e == 1)
        check_eq("fair_ready_e1", 256'(rdy), 256'(4'b1111));
      else
        check_eq($sformatf("fair_ready_e%0d", e), 256'(rdy), ((e - 2) % 2 == 1) ? 256'(4'b1100) : 256'(4'b0011));
      tick();
      if (e <= 8) begin
        for (int unsigned l = 0; l < 4; l++) begin
          if (rdy[l]) begin
            seqn[l]++;
            set_lane(l, 1'b1, 8'(l*16 + seqn[l]), 64'(l*16 + seqn[l] + 1000));
          end
        end
      end
      if (e == 8) clear_lanes();
      if (e >= 2) begin
        m     = e - 2;
        first = (m % 2 == 1) ? 2 : 0;
        e0    = 8'(first*16 + m/2);
        e1    = 8'((first+1)*16 + m/2);
        check_eq($sformatf("fair_bus_e%0d", e), 256'({cab.forward_valids_o, cab.forward_indexes_o}), 256'({2'b11, e1, e0}));
        for (int unsigned k = 0; k < 2; k++)
          if (cab.forward_valids_o[k]) seen[cab.forward_indexes_o[k*8+4 +: 2]]++;
      end
    end
    for (int unsigned l = 0; l < 4; l++)
      check_eq($sformatf("fair_count_lane%0d", l), 256'(seen[l]), 256'(4));

    // refill on grant, lane 1
    do_reset();
    set_lane(1, 1'b1, 8'd10, 64'd110);
    tick();
    set_lane(1, 1'b1, 8'd11, 64'd111);
    #1;
    check_eq("refill_ready", 256'(cab.lane_ready_o[1]), 256'(1'b1));
    tick();
    clear_lanes();
    check_bus("refill_first", 2'b01, 16'h000a, {64'd0, 64'd110});
    tick();
    check_bus("refill_second", 2'b01, 16'h000b, {64'd0, 64'd111});
    tick();
    check_eq("refill_idle", 256'(cab.forward_valids_o), 256'(2'b00));

    // flush
    do_reset();
    set_lane(0, 1'b1, 8'd1, 64'd11);
    set_lane(1, 1'b1, 8'd2, 64'd12);
    set_lane(2, 1'b1, 8'd3, 64'd13);
    tick();
    clear_lanes();
    cab.flush_i = 1'b1;
    #1;
    check_eq("flush_ready_low", 256'(cab.lane_ready_o), 256'(4'b0000));
    tick();
    cab.flush_i = 1'b0;
    check_bus("flush_next", 2'b00, 16'h0, 128'h0);
    #1;
    check_eq("flush_ready_back", 256'(cab.lane_ready_o), 256'(4'b1111));
    tick();
    check_eq("flush_later1", 256'(cab.forward_valids_o), 256'(2'b00));
    tick();
    check_eq("flush_later2", 256'(cab.forward_valids_o), 256'(2'b00));

    // async reset while busses valid
    do_reset();
    set_lane(0, 1'b1, 8'd3, 64'd1003);
    set_lane(1, 1'b1, 8'd4, 64'd1004);
    set_lane(2, 1'b1, 8'd6, 64'd1006);
    set_lane(3, 1'b1, 8'd7, 64'd1007);
    tick();
    clear_lanes();
    tick();
    check_eq("areset_pre", 256'(cab.forward_valids_o), 256'(2'b11));
    #2;
    rst = 1'b1;
    #1;
    check_bus("areset_mid", 2'b00, 16'h0, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("areset_ready", 256'(cab.lane_ready_o), 256'(4'b1111));
    tick();
    check_eq("areset_after1", 256'(cab.forward_valids_o), 256'(2'b00));
    tick();
    check_eq("areset_after2", 256'(cab.forward_valids_o), 256'(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
